// File: rtl/k_and_s_datapath.sv
// K&S multicycle processor datapath: PC, IR, 4-entry register file, ALU and flags.
// Optional build macro KS_DP_ZERO_R0_EN makes R0 a hardwired zero register.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;
endpackage

module k_and_s_datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] r_view [4];

  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              alu_uov, alu_sov;

  logic              wr_en;
  logic [1:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    decoded_instruction = I_NOP;
    case (ir[15:8])
      8'h00: decoded_instruction = I_NOP;
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNZERO;
      8'h04: decoded_instruction = I_BNEG;
      8'h05: decoded_instruction = I_BNNEG;
      8'h06: decoded_instruction = I_BOV;
      8'h07: decoded_instruction = I_BNOV;
      8'h81: decoded_instruction = I_LOAD;
      8'h82: decoded_instruction = I_STORE;
      8'h91: decoded_instruction = I_MOVE;
      8'hA1: decoded_instruction = I_ADD;
      8'hA2: decoded_instruction = I_SUB;
      8'hA3: decoded_instruction = I_AND;
      8'hA4: decoded_instruction = I_OR;
      8'hFF: decoded_instruction = I_HALT;
      default: decoded_instruction = I_NOP;
    endcase
  end

  // Read view of the register file; with the zero-R0 option, R0 is forced to 0.
  always_comb begin
    for (int i = 0; i < 4; i++) r_view[i] = regs[i];
`ifdef KS_DP_ZERO_R0_EN
    r_view[0] = '0;
`endif
  end

  assign data_out = r_view[ir[6:5]];
  assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;

  // MOVE reuses the OR path with both operands taken from the source register.
  always_comb begin
    alu_a      = r_view[ir[3:2]];
    alu_b      = (decoded_instruction == I_MOVE) ? alu_a : r_view[ir[1:0]];
    sum_ext    = {1'b0, alu_a} + {1'b0, alu_b};
    diff_ext   = {1'b0, alu_a} - {1'b0, alu_b};
    alu_result = alu_a | alu_b;
    alu_uov    = 1'b0;
    alu_sov    = 1'b0;
    case (operation)
      2'b00: alu_result = alu_a | alu_b;
      2'b01: begin
        alu_result = sum_ext[DATA_W-1:0];
        alu_uov    = sum_ext[DATA_W];
        alu_sov    = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != alu_a[DATA_W-1]);
      end
      2'b10: begin
        alu_result = diff_ext[DATA_W-1:0];
        alu_uov    = diff_ext[DATA_W];
        alu_sov    = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                     (diff_ext[DATA_W-1] != alu_a[DATA_W-1]);
      end
      default: alu_result = alu_a & alu_b;
    endcase
  end

  always_comb begin
    wr_idx  = c_sel ? ir[5:4] : ir[6:5];
    wr_data = c_sel ? alu_result : data_in;
    wr_en   = write_reg_enable;
`ifdef KS_DP_ZERO_R0_EN
    if (wr_idx == 2'd0) wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc                <= '0;
      ir                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (pc_enable) pc <= branch ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
      if (ir_enable) ir <= 16'(data_in);
      if (wr_en) regs[wr_idx] <= wr_data;
      if (flags_reg_enable) begin
        zero_op           <= (alu_result == '0);
        neg_op            <= alu_result[DATA_W-1];
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
    end
  end

  logic unused_bits;
`ifdef KS_DP_ZERO_R0_EN
  assign unused_bits = ^{ir[7], regs[0]};
`else
  assign unused_bits = ir[7];
`endif

endmodule

// File: tb/tb_k_and_s_datapath.sv
// Directed self-checking bench for k_and_s_datapath; expectations are hand-computed
// and adjust when KS_DP_ZERO_R0_EN is defined.
module tb_k_and_s_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n, branch, pc_enable, ir_enable, write_reg_enable;
  logic addr_sel, c_sel, flags_reg_enable;
  logic [1:0] operation;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0] ram_addr;
  logic [15:0] data_out, data_in;

  int n_checks = 0;
  int n_fail = 0;

  k_and_s_datapath #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr),
    .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    addr_sel = 0; c_sel = 0; flags_reg_enable = 0; operation = 2'b00;
  endtask

  task automatic load_ir(input logic [15:0] v);
    data_in = v; ir_enable = 1; step(); ir_enable = 0;
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [15:0] v);
    load_ir(16'h8100 | (16'(r) << 5));
    data_in = v; c_sel = 0; write_reg_enable = 1; step(); write_reg_enable = 0;
  endtask

  task automatic peek_reg(input logic [1:0] r, output logic [15:0] v);
    load_ir(16'h8200 | (16'(r) << 5));
    v = data_out;
  endtask

  task automatic alu_exec(input logic [15:0] instr, input logic [1:0] op);
    load_ir(instr);
    operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0; branch = 1; pc_enable = 1; ir_enable = 1; write_reg_enable = 1;
    addr_sel = 0; c_sel = 1; flags_reg_enable = 1; operation = 2'b01; data_in = 16'hFFFF;
    step(); step();
    idle();
    n_checks++; if (ram_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_pc: got %0d expected 0", ram_addr); end
    addr_sel = 1; #1;
    n_checks++; if (ram_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_ir_addr: got %0d expected 0", ram_addr); end
    addr_sel = 0;
    n_checks++; if (decoded_instruction !== I_NOP) begin n_fail++; $display("[TB] FAIL reset_decode: got %0d expected I_NOP", decoded_instruction); end
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_data_out: got %h expected 0000", data_out); end
    rst_n = 1;
  endtask

  task automatic test_fetch();
    data_in = 16'h8103; ir_enable = 1; pc_enable = 1; step();
    idle();
    n_checks++; if (decoded_instruction !== I_LOAD) begin n_fail++; $display("[TB] FAIL fetch_decode: got %0d expected I_LOAD", decoded_instruction); end
    n_checks++; if (ram_addr !== 5'd1) begin n_fail++; $display("[TB] FAIL fetch_pc: got %0d expected 1", ram_addr); end
    addr_sel = 1; #1;
    n_checks++; if (ram_addr !== 5'd3) begin n_fail++; $display("[TB] FAIL fetch_ir_addr: got %0d expected 3", ram_addr); end
    addr_sel = 0;
  endtask

  task automatic test_load_add();
    logic [15:0] v;
    load_reg(2'd1, 16'h7FFF);
    load_reg(2'd2, 16'h0001);
    alu_exec(16'hA116, 2'b01);
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0101) begin n_fail++;
      $display("[TB] FAIL add_flags: got %b expected 0101", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    peek_reg(2'd1, v);
    n_checks++; if (v !== 16'h8000) begin n_fail++; $display("[TB] FAIL add_result: got %h expected 8000", v); end
  endtask

  task automatic test_sub();
    logic [15:0] v;
    logic [3:0] exp_flags1;
    logic [15:0] exp_r0;
`ifdef KS_DP_ZERO_R0_EN
    exp_flags1 = 4'b0110;
    exp_r0 = 16'h0000;
`else
    exp_flags1 = 4'b1000;
    exp_r0 = 16'hFFFB;
`endif
    load_reg(2'd0, 16'd5);
    load_reg(2'd3, 16'd5);
    alu_exec(16'hA203, 2'b10);
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== exp_flags1) begin n_fail++;
      $display("[TB] FAIL sub_zero_flags: got %b expected %b", {zero_op, neg_op, unsigned_overflow, signed_overflow}, exp_flags1); end
    alu_exec(16'hA203, 2'b10);
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0110) begin n_fail++;
      $display("[TB] FAIL sub_borrow_flags: got %b expected 0110", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    peek_reg(2'd0, v);
    n_checks++; if (v !== exp_r0) begin n_fail++; $display("[TB] FAIL sub_result: got %h expected %h", v, exp_r0); end
  endtask

  task automatic test_and_or();
    logic [15:0] v;
    load_reg(2'd1, 16'hF0F0);
    load_reg(2'd2, 16'h0FF0);
    alu_exec(16'hA336, 2'b11);
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin n_fail++;
      $display("[TB] FAIL and_flags: got %b expected 0000", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    peek_reg(2'd3, v);
    n_checks++; if (v !== 16'h00F0) begin n_fail++; $display("[TB] FAIL and_result: got %h expected 00f0", v); end
    alu_exec(16'hA436, 2'b00);
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0100) begin n_fail++;
      $display("[TB] FAIL or_flags: got %b expected 0100", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    peek_reg(2'd3, v);
    n_checks++; if (v !== 16'hFFF0) begin n_fail++; $display("[TB] FAIL or_result: got %h expected fff0", v); end
    load_ir(16'h0000);
    flags_reg_enable = 0; step();
    n_checks++; if (neg_op !== 1'b1) begin n_fail++; $display("[TB] FAIL flags_hold: got %b expected 1", neg_op); end
  endtask

  task automatic test_branch_wrap();
    load_ir(16'h0114);
    n_checks++; if (decoded_instruction !== I_BRANCH) begin n_fail++; $display("[TB] FAIL branch_decode: got %0d expected I_BRANCH", decoded_instruction); end
    branch = 1; pc_enable = 1; step(); idle();
    n_checks++; if (ram_addr !== 5'd20) begin n_fail++; $display("[TB] FAIL branch_pc: got %0d expected 20", ram_addr); end
    pc_enable = 1;
    for (int i = 0; i < 11; i++) step();
    pc_enable = 0; #1;
    n_checks++; if (ram_addr !== 5'd31) begin n_fail++; $display("[TB] FAIL pc_31: got %0d expected 31", ram_addr); end
    pc_enable = 1; step(); pc_enable = 0;
    n_checks++; if (ram_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL pc_wrap: got %0d expected 0", ram_addr); end
  endtask

  task automatic test_move_store();
    logic [15:0] exp_r0;
`ifdef KS_DP_ZERO_R0_EN
    exp_r0 = 16'h0000;
`else
    exp_r0 = 16'h1234;
`endif
    load_reg(2'd3, 16'h1234);
    load_reg(2'd1, 16'h5555);
    alu_exec(16'h910D, 2'b00);
    load_ir(16'h8205);
    n_checks++; if (data_out !== exp_r0) begin n_fail++; $display("[TB] FAIL move_store_data: got %h expected %h", data_out, exp_r0); end
    addr_sel = 1; #1;
    n_checks++; if (ram_addr !== 5'd5) begin n_fail++; $display("[TB] FAIL store_addr: got %0d expected 5", ram_addr); end
    addr_sel = 0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    load_ir(16'hA336);
    pc_enable = 1; step(); pc_enable = 0;
    operation = 2'b00; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1; rst_n = 0;
    step();
    idle(); rst_n = 1;
    n_checks++; if (ram_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_reset_pc: got %0d expected 0", ram_addr); end
    n_checks++; if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin n_fail++;
      $display("[TB] FAIL mid_reset_flags: got %b expected 0000", {zero_op, neg_op, unsigned_overflow, signed_overflow}); end
    n_checks++; if (decoded_instruction !== I_NOP) begin n_fail++; $display("[TB] FAIL mid_reset_decode: got %0d expected I_NOP", decoded_instruction); end
    peek_reg(2'd3, v);
    n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_r3: got %h expected 0000", v); end
    peek_reg(2'd1, v);
    n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_r1: got %h expected 0000", v); end
  endtask

  initial begin
    data_in = '0;
    rst_n = 0;
    idle();
    #1;
    test_reset();
    test_fetch();
    test_load_add();
    test_sub();
    test_and_or();
    test_branch_wrap();
    test_move_store();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
